// File: rtl/fpaddsub_pkg.sv
// fpaddsub_pkg: shared widths, constants and result bundle for the FP add/sub normalize stage
package fpaddsub_pkg;
   localparam int MANT_W = 26;
   localparam int EXP_W = 8;
   localparam int SHIFT_W = 6;
   localparam logic [EXP_W-1:0] EXP_MAX = '1;
   localparam int HIDDEN_BIT = 24;
   localparam logic [SHIFT_W-1:0] LNC_ZERO = 6'd26;
   typedef struct packed {
      logic [MANT_W-1:0] mant;
      logic [EXP_W-1:0]  exp;
      logic              sign;
      logic              zero;
      logic              uf;
      logic              ovf;
   } norm_res_t;
endpackage

// File: rtl/fpaddsub_norm_shifter.sv
// fpaddsub_norm_shifter: right-by-1 with sticky (lnc==0) or left-by-(lnc-1) significand shift
//   sum  : raw significand sum
//   lnc  : leading-nought count, already clamped to 0..26
//   mant : shifted significand
module fpaddsub_norm_shifter
   import fpaddsub_pkg::*;
(
   input  logic [MANT_W-1:0]  sum,
   input  logic [SHIFT_W-1:0] lnc,
   output logic [MANT_W-1:0]  mant
);
   always_comb
      mant = (lnc == '0) ? {1'b0, sum[MANT_W-1:2], |sum[1:0]} : sum << (lnc - SHIFT_W'(1));
endmodule

// File: rtl/fpaddsub_normalize_stage.sv
// fpaddsub_normalize_stage: 2-stage elastic normalization of the FP add/sub significand sum
//   clk, rst (async, active-low)
//   in_valid/in_ready, in_sum, in_exp, in_sign, in_lnc : unnormalized sum from the LNC stage
//   out_valid/out_ready, out_mant, out_exp, out_sign, out_zero, out_uf, out_ovf : to rounding
module fpaddsub_normalize_stage
   import fpaddsub_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [MANT_W-1:0]  in_sum,
   input  logic [EXP_W-1:0]   in_exp,
   input  logic               in_sign,
   input  logic [SHIFT_W-1:0] in_lnc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [MANT_W-1:0]  out_mant,
   output logic [EXP_W-1:0]   out_exp,
   output logic               out_sign,
   output logic               out_zero,
   output logic               out_uf,
   output logic               out_ovf
);
   logic               s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic [MANT_W-1:0]  s1_mant_q, s1_mant_d, sh_mant;
   logic [SHIFT_W-1:0] s1_lnc_q, s1_lnc_d, lnc_c;
   logic [EXP_W-1:0]   s1_exp_q, s1_exp_d;
   logic               s1_sign_q, s1_sign_d;
   logic               s1_adv, s2_adv, zero, ovf, uf;
   // two guard bits so both exp+1 (up to 256) and exp-24 (down to -24) fit as two's complement
   logic [EXP_W+1:0]   adj;
   norm_res_t          res_q, res_d, res_n;

   fpaddsub_norm_shifter u_shifter (
      .sum  (in_sum),
      .lnc  (lnc_c),
      .mant (sh_mant)
   );

   always_comb begin
      s2_adv = !s2_valid_q || out_ready;
      s1_adv = !s1_valid_q || s2_adv;
      in_ready = s1_adv;
      lnc_c = (in_lnc > LNC_ZERO) ? LNC_ZERO : in_lnc;
      s1_valid_d = s1_adv ? in_valid : s1_valid_q;
      s1_mant_d = (s1_adv && in_valid) ? sh_mant : s1_mant_q;
      s1_lnc_d = (s1_adv && in_valid) ? lnc_c : s1_lnc_q;
      s1_exp_d = (s1_adv && in_valid) ? in_exp : s1_exp_q;
      s1_sign_d = (s1_adv && in_valid) ? in_sign : s1_sign_q;
      adj = (EXP_W+2)'(s1_exp_q) - (EXP_W+2)'(s1_lnc_q) + (EXP_W+2)'(1);
      if (s1_lnc_q == '0)
         adj = (EXP_W+2)'(s1_exp_q) + (EXP_W+2)'(1);
      zero = s1_lnc_q == LNC_ZERO;
      ovf = !zero && s1_lnc_q == '0 && adj >= (EXP_W+2)'(EXP_MAX);
      uf = !zero && !ovf && (adj[EXP_W+1] || adj == '0);
      res_n.mant = (zero || ovf || uf) ? '0 : s1_mant_q;
      res_n.exp = ovf ? EXP_MAX : (zero || uf) ? '0 : adj[EXP_W-1:0];
      res_n.sign = s1_sign_q;
      res_n.zero = zero;
      res_n.uf = uf;
      res_n.ovf = ovf;
      s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
      res_d = (s2_adv && s1_valid_q) ? res_n : res_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_mant_q <= '0;
         s1_lnc_q <= '0;
         s1_exp_q <= '0;
         s1_sign_q <= 1'b0;
         res_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s1_mant_q <= s1_mant_d;
         s1_lnc_q <= s1_lnc_d;
         s1_exp_q <= s1_exp_d;
         s1_sign_q <= s1_sign_d;
         res_q <= res_d;
      end
   end

   always_comb begin
      out_valid = s2_valid_q;
      out_mant = res_q.mant;
      out_exp = res_q.exp;
      out_sign = res_q.sign;
      out_zero = res_q.zero;
      out_uf = res_q.uf;
      out_ovf = res_q.ovf;
   end
endmodule
